// File: rtl/inta_sequencer.sv
// INTA acknowledge sequencer for an 8259-style controller: nested priority resolution,
// in-service tracking, two-pulse INTA handshake, cascade addressing and vector drive.
module inta_sequencer #(
  parameter int unsigned INTA_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sp_en,
  input  logic [7:0] icw3,
  input  logic [4:0] icw2_base,
  input  logic       aeoi,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       eoi,
  input  logic       inta_n,
  input  logic [2:0] cas_in,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] irr_clear,
  output logic       inta_first_pulse,
  output logic       inta_second_pulse,
  output logic [7:0] data_out,
  output logic       data_oe
);
  localparam int unsigned CNT_W = (INTA_TIMEOUT > 0) ? $clog2(INTA_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INTA_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT1, S_ACK1, S_WAIT2, S_ACK2} state_t;

  state_t           state;
  logic             inta_q;
  logic             fall;
  logic             win_vld;
  logic             cas_match;
  logic             first_act;
  logic             aeoi_act;
  logic [7:0]       nest_mask;
  logic [7:0]       cand;
  logic [7:0]       eoi_clr;
  logic [7:0]       isr_set;
  logic [7:0]       isr_clr;
  logic [2:0]       win;
  logic [2:0]       w_q;
  logic             spurious;
  logic             selected;
  logic [CNT_W-1:0] cnt;

  // Priority resolution against the fully nested in-service level, plus isr set/clear events.
  always_comb begin
    nest_mask = 8'hff;
    for (int i = 7; i >= 0; i--) begin
      if (isr[i]) nest_mask = (8'd1 << i) - 8'd1;
    end
    cand    = irr & ~imr & nest_mask;
    win_vld = |cand;
    win     = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) win = 3'(i);
    end
    eoi_clr   = isr & (~isr + 8'd1);
    fall      = inta_q & ~inta_n;
    cas_match = sp_en | (cas_in == icw3[2:0]);
    first_act = ((state == S_IDLE) || (state == S_WAIT1)) && fall && win_vld && cas_match;
    aeoi_act  = (state == S_ACK2) && inta_n && aeoi && selected && !spurious;
    isr_set   = first_act ? (8'd1 << win) : 8'h00;
    isr_clr   = (eoi ? eoi_clr : 8'h00) | (aeoi_act ? (8'd1 << w_q) : 8'h00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      isr               <= '0;
      int_out           <= 1'b0;
      cas_out           <= '0;
      cas_oe            <= 1'b0;
      data_out          <= '0;
      data_oe           <= 1'b0;
      irr_clear         <= '0;
      inta_first_pulse  <= 1'b0;
      inta_second_pulse <= 1'b0;
      cnt               <= '0;
      // Low so that INTA held low across reset release is not taken as a fresh edge
      inta_q            <= 1'b0;
      w_q               <= '0;
      spurious          <= 1'b0;
      selected          <= 1'b0;
    end else begin
      inta_q            <= inta_n;
      isr               <= (isr & ~isr_clr) | isr_set;
      irr_clear         <= isr_set;
      inta_first_pulse  <= 1'b0;
      inta_second_pulse <= 1'b0;
      int_out           <= 1'b0;
      case (state)
        S_IDLE, S_WAIT1: begin
          if (fall) begin
            state            <= S_ACK1;
            inta_first_pulse <= 1'b1;
            w_q              <= win;
            spurious         <= ~win_vld;
            selected         <= cas_match;
            if (sp_en && icw3[win]) begin
              cas_out <= win;
              cas_oe  <= 1'b1;
            end
          end else if (win_vld) begin
            state   <= S_WAIT1;
            int_out <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ACK1: begin
          if (inta_n) begin
            state <= S_WAIT2;
            cnt   <= CNT_W'(1);
          end
        end
        // cnt holds the number of high INTA cycles seen since the first pulse ended
        S_WAIT2: begin
          if (fall) begin
            state             <= S_ACK2;
            inta_second_pulse <= 1'b1;
            if (selected && !(sp_en && icw3[w_q])) begin
              data_out <= {icw2_base, w_q};
              data_oe  <= 1'b1;
            end
          end else if (cnt == CNT_MAX) begin
            state   <= S_IDLE;
            cas_out <= '0;
            cas_oe  <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACK2: begin
          if (inta_n) begin
            state    <= S_IDLE;
            data_out <= '0;
            data_oe  <= 1'b0;
            cas_out  <= '0;
            cas_oe   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
